// File: rtl/mips_cpu_store_buffer.sv
// rtl/mips_cpu_store_buffer.sv - posted-write store buffer between store merge and data memory
// Optional feature macro: MIPS_CPU_STORE_BUFFER_FWD_EN (full-word forwarding of buffered stores to loads)
module mips_cpu_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   st_valid,
  output logic                   st_ready,
  input  logic [AW-1:0]          st_addr,
  input  logic [31:0]            st_data,
  input  logic [3:0]             st_byteenable,
  output logic                   mem_write,
  output logic [AW-1:0]          mem_address,
  output logic [31:0]            mem_writedata,
  output logic [3:0]             mem_byteenable,
  input  logic                   mem_waitrequest,
  input  logic                   ld_check,
  input  logic [AW-1:0]          ld_addr,
  output logic                   ld_hit,
  output logic                   ld_fwd_valid,
  output logic [31:0]            ld_fwd_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_WRITE = 1'b1;

  logic [AW-3:0]    r_addr [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [3:0]       r_be   [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [0:0]       r_state;
  logic [AW-1:0]    r_mem_address;
  logic [31:0]      r_mem_writedata;
  logic [3:0]       r_mem_byteenable;

  logic          w_push;
  logic          w_pop;
  logic          w_load;
  logic          w_more;
  logic [0:0]    w_next_state;
  logic [PW-1:0] w_next_ptr;
  logic [AW-3:0] w_cand_addr;
  logic [31:0]   w_cand_data;
  logic [3:0]    w_cand_be;
  logic [AW-3:0] w_src_addr;
  logic [31:0]   w_src_data;
  logic [3:0]    w_src_be;
  logic          w_match_any;
  logic          w_unused_bits;

  // Ready comes from registered occupancy only, so a full buffer never refills in the pop cycle
  assign st_ready   = !reset && (r_count < CW'(DEPTH));
  assign w_push     = st_valid && st_ready;
  assign w_next_ptr = r_rd_ptr + PW'(1);

  // Entry following the head; when the head is the only entry it can only come from the input port
  assign w_more      = (r_count > CW'(1)) || w_push;
  assign w_cand_addr = (r_count > CW'(1)) ? r_addr[w_next_ptr] : st_addr[AW-1:2];
  assign w_cand_data = (r_count > CW'(1)) ? r_data[w_next_ptr] : st_data;
  assign w_cand_be   = (r_count > CW'(1)) ? r_be[w_next_ptr]   : st_byteenable;

  // Drain control: pick what to pop, what to present to memory and the next state
  always_comb begin
    w_pop        = 1'b0;
    w_load       = 1'b0;
    w_next_state = r_state;
    w_src_addr   = r_addr[r_rd_ptr];
    w_src_data   = r_data[r_rd_ptr];
    w_src_be     = r_be[r_rd_ptr];
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          if (r_be[r_rd_ptr] == 4'b0000) begin
            w_pop = 1'b1;
          end else begin
            w_load       = 1'b1;
            w_next_state = S_WRITE;
          end
        end
      end
      default: begin
        if (!mem_waitrequest) begin
          w_pop      = 1'b1;
          w_src_addr = w_cand_addr;
          w_src_data = w_cand_data;
          w_src_be   = w_cand_be;
          // A zero-lane follower is left for IDLE to discard so it never reaches memory
          if (w_more && (w_cand_be != 4'b0000)) begin
            w_load = 1'b1;
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
    endcase
  end

  // Entry storage; contents are qualified by r_valid so they need no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= st_addr[AW-1:2];
      r_data[r_wr_ptr] <= st_data;
      r_be[r_wr_ptr]   <= st_byteenable;
    end
  end

  // Pointers, occupancy, state and the registered memory request
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid          <= '0;
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_count          <= '0;
      r_state          <= S_IDLE;
      r_mem_address    <= '0;
      r_mem_writedata  <= '0;
      r_mem_byteenable <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= w_next_ptr;
      end
      if (w_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      r_state <= w_next_state;
      if (w_load) begin
        r_mem_address    <= {w_src_addr, 2'b00};
        r_mem_writedata  <= w_src_data;
        r_mem_byteenable <= w_src_be;
      end
    end
  end

  // Load hazard: any buffered store, including the one being written, to the same word
  always_comb begin
    w_match_any = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_addr[i] == ld_addr[AW-1:2])) begin
        w_match_any = 1'b1;
      end
    end
  end

  assign ld_hit = ld_check && w_match_any;

`ifdef MIPS_CPU_STORE_BUFFER_FWD_EN
  logic [PW-1:0] w_scan_idx;
  logic [31:0]   w_young_data;
  logic [3:0]    w_young_be;

  // Walk oldest to youngest so the last match found is the most recent store
  always_comb begin
    w_scan_idx   = r_rd_ptr;
    w_young_data = '0;
    w_young_be   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_scan_idx = r_rd_ptr + PW'(k);
      if (r_valid[w_scan_idx] && (r_addr[w_scan_idx] == ld_addr[AW-1:2])) begin
        w_young_data = r_data[w_scan_idx];
        w_young_be   = r_be[w_scan_idx];
      end
    end
  end

  assign ld_fwd_valid = ld_hit && (w_young_be == 4'b1111);
  assign ld_fwd_data  = ld_fwd_valid ? w_young_data : 32'h0;
`else
  assign ld_fwd_valid = 1'b0;
  assign ld_fwd_data  = 32'h0;
`endif

  assign w_unused_bits  = ^{st_addr[1:0], ld_addr[1:0]};
  assign mem_write      = (r_state == S_WRITE);
  assign mem_address    = r_mem_address;
  assign mem_writedata  = r_mem_writedata;
  assign mem_byteenable = r_mem_byteenable;
  assign empty          = (r_count == '0) && (r_state == S_IDLE);
  assign count          = r_count;

endmodule

// File: tb/tb_mips_cpu_store_buffer.sv
// tb/tb_mips_cpu_store_buffer.sv - self-checking bench for mips_cpu_store_buffer
module tb_mips_cpu_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
`ifdef MIPS_CPU_STORE_BUFFER_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_byteenable;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_waitrequest;
  logic        ld_check;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic        ld_fwd_valid;
  logic [31:0] ld_fwd_data;
  logic        empty;
  logic [2:0]  count;

  always #5 clk = ~clk;

  mips_cpu_store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_byteenable(st_byteenable),
    .mem_write(mem_write), .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_byteenable(mem_byteenable), .mem_waitrequest(mem_waitrequest),
    .ld_check(ld_check), .ld_addr(ld_addr), .ld_hit(ld_hit),
    .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data),
    .empty(empty), .count(count)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          cyc;
  } wr_t;

  typedef struct packed {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } st_t;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  wr_t wlog[$];
  st_t pend[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_write(input string tag, input int idx, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] be);
    if (idx < wlog.size()) begin
      check({tag, "_addr"}, wlog[idx].addr, a);
      check({tag, "_data"}, wlog[idx].data, d);
      check({tag, "_be"},   wlog[idx].be,   be);
    end else begin
      check({tag, "_present"}, wlog.size(), idx + 1);
    end
  endtask

  task automatic put_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    st_valid      = 1'b1;
    st_addr       = a;
    st_data       = d;
    st_byteenable = be;
  endtask

  // One cycle of the reference model: the buffer is an ordered list of accepted, unwritten stores
  task automatic model_step(input bit rnd);
    bit          push;
    bit          pop;
    bit          hit;
    logic [31:0] yd;
    logic [3:0]  ybe;
    if (rnd) begin
      st_valid        = 1'($urandom_range(0, 1));
      st_addr         = 32'h8000 + ($urandom_range(0, 5) << 2) + $urandom_range(0, 3);
      st_data         = $urandom;
      st_byteenable   = 4'($urandom_range(1, 15));
      mem_waitrequest = ($urandom_range(0, 9) < 4);
      ld_check        = 1'($urandom_range(0, 1));
      ld_addr         = 32'h8000 + ($urandom_range(0, 5) << 2) + $urandom_range(0, 3);
    end
    #1;
    check("rnd_ready", st_ready, pend.size() < DEPTH);
    check("rnd_count", count, pend.size());
    check("rnd_empty", empty, pend.size() == 0);
    hit = 1'b0;
    yd  = '0;
    ybe = '0;
    foreach (pend[k]) begin
      if (pend[k].a == ld_addr[31:2]) begin
        hit = 1'b1;
        yd  = pend[k].d;
        ybe = pend[k].be;
      end
    end
    hit = hit && ld_check;
    check("rnd_ld_hit", ld_hit, hit);
    check("rnd_fwd_valid", ld_fwd_valid, FWD && hit && (ybe == 4'hF));
    check("rnd_fwd_data", ld_fwd_data, (FWD && hit && (ybe == 4'hF)) ? yd : 32'h0);
    if (mem_write) begin
      if (pend.size() == 0) begin
        check("rnd_spurious_write", mem_write, 1'b0);
      end else begin
        check("rnd_wr_addr", mem_address, {pend[0].a, 2'b00});
        check("rnd_wr_data", mem_writedata, pend[0].d);
        check("rnd_wr_be", mem_byteenable, pend[0].be);
      end
    end
    push = st_valid && (pend.size() < DEPTH);
    pop  = mem_write && !mem_waitrequest;
    tick();
    if (pop && pend.size() > 0) pend.pop_front();
    if (push) pend.push_back({st_addr[31:2], st_data, st_byteenable});
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Write log plus request-stability check while memory stalls
  logic        prev_hold  = 1'b0;
  logic        prev_reset = 1'b1;
  logic [31:0] prev_addr, prev_data;
  logic [3:0]  prev_be;
  always @(negedge clk) begin
    if (prev_hold && !prev_reset) begin
      check("hold_write", mem_write, 1'b1);
      check("hold_addr", mem_address, prev_addr);
      check("hold_data", mem_writedata, prev_data);
      check("hold_be", mem_byteenable, prev_be);
    end
    if (mem_write === 1'b1 && mem_waitrequest === 1'b0)
      wlog.push_back({mem_address, mem_writedata, mem_byteenable, cyc});
    prev_hold  = (mem_write === 1'b1) && (mem_waitrequest === 1'b1);
    prev_reset = reset;
    prev_addr  = mem_address;
    prev_data  = mem_writedata;
    prev_be    = mem_byteenable;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    bit          accepted;
    logic [31:0] fd[5];

    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_byteenable = '0;
    mem_waitrequest = 1'b0; ld_check = 1'b1; ld_addr = '0;
    tick(); tick();
    check("rst_ready", st_ready, 1'b0);
    check("rst_write", mem_write, 1'b0);
    check("rst_addr", mem_address, 32'h0);
    check("rst_data", mem_writedata, 32'h0);
    check("rst_be", mem_byteenable, 4'h0);
    check("rst_hit", ld_hit, 1'b0);
    check("rst_fwd", {ld_fwd_valid, ld_fwd_data}, 33'h0);
    check("rst_empty", empty, 1'b1);
    check("rst_count", count, 3'd0);
    reset = 1'b0; ld_check = 1'b0;
    #1 check("post_rst_ready", st_ready, 1'b1);

    // Single store, no wait
    base = wlog.size();
    put_store(32'h106, 32'hAABBCCDD, 4'hF);
    tick();
    st_valid = 1'b0;
    #1 check("single_count", count, 3'd1);
    check("single_not_yet", mem_write, 1'b0);
    tick();
    check("single_write", mem_write, 1'b1);
    check("single_addr", mem_address, 32'h104);
    check("single_data", mem_writedata, 32'hAABBCCDD);
    tick();
    check("single_done", mem_write, 1'b0);
    check("single_empty", empty, 1'b1);
    check("single_nwrites", wlog.size(), base + 1);
    check_write("single_log", base, 32'h104, 32'hAABBCCDD, 4'hF);

    // Fill with memory stalled, then release
    base = wlog.size();
    mem_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) fd[i] = $urandom;
    for (int i = 0; i < 4; i++) begin
      put_store(32'h1000 + 32'(16 * i), fd[i], 4'hF);
      #1 check("fill_ready", st_ready, 1'b1);
      tick();
    end
    put_store(32'h1040, fd[4], 4'hF);
    for (int i = 0; i < 3; i++) begin
      #1 check("full_ready", st_ready, 1'b0);
      check("full_count", count, 3'd4);
      tick();
    end
    mem_waitrequest = 1'b0;
    #1 check("full_no_refill", st_ready, 1'b0);
    accepted = 1'b0;
    for (int c = 0; c < 20 && !accepted; c++) begin
      #1 if (st_ready) accepted = 1'b1;
      tick();
    end
    st_valid = 1'b0;
    check("fill_fifth_accepted", accepted, 1'b1);
    for (int c = 0; c < 20; c++) tick();
    check("fill_nwrites", wlog.size(), base + 5);
    for (int i = 0; i < 5; i++) begin
      check_write("fill_order", base + i, 32'h1000 + 32'(16 * i), fd[i], 4'hF);
      if (i > 0 && base + i < wlog.size())
        check("fill_b2b", wlog[base + i].cyc - wlog[base + i - 1].cyc, 1);
    end
    check("fill_count", count, 3'd0);

    // Request stable under waitrequest
    base = wlog.size();
    mem_waitrequest = 1'b1;
    put_store(32'h900, 32'h5A5AA5A5, 4'b0110);
    tick();
    st_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("stall_write", mem_write, 1'b1);
      check("stall_addr", mem_address, 32'h900);
      check("stall_data", mem_writedata, 32'h5A5AA5A5);
      check("stall_be", mem_byteenable, 4'b0110);
      tick();
    end
    mem_waitrequest = 1'b0;
    tick(); tick();
    check("stall_single_pop", wlog.size(), base + 1);
    check("stall_count", count, 3'd0);

    // Hazard and forwarding
    base = wlog.size();
    mem_waitrequest = 1'b1;
    put_store(32'h200, 32'h11223344, 4'hF);
    tick();
    put_store(32'h300, 32'h55667788, 4'b0011);
    tick();
    st_valid = 1'b0;
    ld_check = 1'b1; ld_addr = 32'h202;
    #1 check("haz_hit_full", ld_hit, 1'b1);
    check("haz_fwd_valid", ld_fwd_valid, FWD);
    check("haz_fwd_data", ld_fwd_data, FWD ? 32'h11223344 : 32'h0);
    ld_addr = 32'h301;
    #1 check("haz_hit_partial", ld_hit, 1'b1);
    check("haz_partial_fwd", ld_fwd_valid, 1'b0);
    ld_addr = 32'h400;
    #1 check("haz_miss", ld_hit, 1'b0);
    ld_check = 1'b0; ld_addr = 32'h200;
    #1 check("haz_no_check", ld_hit, 1'b0);
    tick();
    put_store(32'h200, 32'h99AABBCC, 4'hF);
    tick();
    st_valid = 1'b0; ld_check = 1'b1; ld_addr = 32'h203;
    #1 check("haz_young_fwd", ld_fwd_data, FWD ? 32'h99AABBCC : 32'h0);
    put_store(32'h500, 32'hCAFEF00D, 4'hF);
    ld_addr = 32'h500;
    #1 check("haz_enq_not_checked", ld_hit, 1'b0);
    tick();
    st_valid = 1'b0;
    #1 check("haz_enq_now_hit", ld_hit, 1'b1);
    ld_check = 1'b0;
    mem_waitrequest = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    check("haz_nwrites", wlog.size(), base + 4);
    check_write("haz_w0", base + 0, 32'h200, 32'h11223344, 4'hF);
    check_write("haz_w1", base + 1, 32'h300, 32'h55667788, 4'b0011);
    check_write("haz_w2", base + 2, 32'h200, 32'h99AABBCC, 4'hF);
    check_write("haz_w3", base + 3, 32'h500, 32'hCAFEF00D, 4'hF);

    // Reset during a stalled write
    base = wlog.size();
    mem_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      put_store(32'hA00 + 32'(4 * i), 32'h100 + 32'(i), 4'hF);
      tick();
    end
    st_valid = 1'b0;
    check("rstmid_pre_write", mem_write, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_write", mem_write, 1'b0);
    check("rstmid_count", count, 3'd0);
    check("rstmid_empty", empty, 1'b1);
    check("rstmid_addr", mem_address, 32'h0);
    ld_check = 1'b1; ld_addr = 32'hA00;
    #1 check("rstmid_hit", ld_hit, 1'b0);
    ld_check = 1'b0;
    mem_waitrequest = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    check("rstmid_no_writes", wlog.size(), base);

    // Zero-enable store between two normal stores
    base = wlog.size();
    put_store(32'h700, 32'h01010101, 4'hF);
    tick();
    put_store(32'h704, 32'h02020202, 4'h0);
    tick();
    put_store(32'h708, 32'h03030303, 4'b1000);
    tick();
    st_valid = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    check("zbe_nwrites", wlog.size(), base + 2);
    check_write("zbe_w0", base + 0, 32'h700, 32'h01010101, 4'hF);
    check_write("zbe_w1", base + 1, 32'h708, 32'h03030303, 4'b1000);
    check("zbe_count", count, 3'd0);
    check("zbe_empty", empty, 1'b1);

    // Randomized traffic against the reference model, then a bounded drain
    pend.delete();
    for (int i = 0; i < 400; i++) model_step(1'b1);
    st_valid = 1'b0; mem_waitrequest = 1'b0;
    for (int i = 0; i < 40 && pend.size() > 0; i++) model_step(1'b0);
    check("rnd_drained", pend.size(), 0);
    #1 check("rnd_final_empty", empty, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
